// File: rtl/lanzones.sv
// Multicycle RV32I core with a single shared memory port.
// States: IDLE -> FETCH -> EXEC -> (MEM) -> WB -> FETCH; ECALL/EBREAK/illegal -> HALT.
module lanzones (
    input  logic        clk,
    input  logic        rstn,
    input  logic        LEn,
    output logic        RRdy,
    output logic [31:0] RAddr,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        RWEn,
    output logic [31:0] RWData,
    output logic [3:0]  RWStrobe,
    output logic        Halt
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state, state_nxt;
    logic [31:0] pc, ir, result, next_pc, ea;
    logic [31:0] regs [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_out, exec_result, exec_next_pc, exec_ea, load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        alu_alt, take, illegal, is_load, is_store, is_branch;

    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign funct7    = ir[31:25];
    assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4  = pc + 32'd4;
    assign imm_i     = {{20{ir[31]}}, ir[31:20]};
    assign imm_s     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u     = {ir[31:12], 12'd0};
    assign imm_j     = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // ir[30] selects SUB/SRA for register ops, but only SRAI among immediates
    assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
    assign alu_alt = ir[30] && ((opcode == OP_REG) || (funct3 == 3'b101));

    always_comb begin
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                      : rs1_val >> alu_b[4:0];
            3'b110: alu_out = rs1_val | alu_b;
            3'b111: alu_out = rs1_val & alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000: take = (rs1_val == rs2_val);
            3'b001: take = (rs1_val != rs2_val);
            3'b100: take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: take = (rs1_val < rs2_val);
            3'b111: take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    // For stores the result register carries rs2 through to the MEM phase
    always_comb begin
        exec_result  = 32'd0;
        exec_next_pc = pc_plus4;
        exec_ea      = rs1_val + imm_i;
        illegal      = 1'b0;
        case (opcode)
            OP_LUI:   exec_result = imm_u;
            OP_AUIPC: exec_result = pc + imm_u;
            OP_JAL: begin
                exec_result  = pc_plus4;
                exec_next_pc = pc + imm_j;
            end
            OP_JALR: begin
                exec_result  = pc_plus4;
                exec_next_pc = (rs1_val + imm_i) & ~32'd1;
                illegal      = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                if (take)
                    exec_next_pc = pc + imm_b;
                illegal = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OP_STORE: begin
                exec_ea     = rs1_val + imm_s;
                exec_result = rs2_val;
                illegal     = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OP_IMM: begin
                exec_result = alu_out;
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_REG: begin
                exec_result = alu_out;
                illegal = !((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        load_byte = RData[7:0];
        case (ea[1:0])
            2'd1: load_byte = RData[15:8];
            2'd2: load_byte = RData[23:16];
            2'd3: load_byte = RData[31:24];
            default: load_byte = RData[7:0];
        endcase
        load_half = ea[1] ? RData[31:16] : RData[15:0];
        case (funct3)
            3'b000: load_val = {{24{load_byte[7]}}, load_byte};
            3'b001: load_val = {{16{load_half[15]}}, load_half};
            3'b100: load_val = {24'd0, load_byte};
            3'b101: load_val = {16'd0, load_half};
            default: load_val = RData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            pc      <= 32'd0;
            ir      <= 32'd0;
            result  <= 32'd0;
            next_pc <= 32'd0;
            ea      <= 32'd0;
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: if (RVld) ir <= RData;
                EXEC: begin
                    result  <= exec_result;
                    next_pc <= exec_next_pc;
                    ea      <= exec_ea;
                end
                MEM: if (is_load && RVld) result <= load_val;
                WB: begin
                    if (!is_store && !is_branch && rd != 5'd0)
                        regs[rd] <= result;
                    pc <= next_pc;
                end
                default: ;
            endcase
        end
    end

    // Write enable is gated by reset so a store caught by reset never lands
    always_comb begin
        state_nxt = state;
        RRdy      = 1'b0;
        RAddr     = 32'd0;
        RWEn      = 1'b0;
        RWData    = 32'd0;
        RWStrobe  = 4'd0;
        Halt      = (state == HALT);
        case (state)
            IDLE:  if (LEn) state_nxt = FETCH;
            FETCH: begin
                RRdy  = 1'b1;
                RAddr = {2'b00, pc[31:2]};
                if (RVld) state_nxt = EXEC;
            end
            EXEC: begin
                if (illegal)                  state_nxt = HALT;
                else if (is_load || is_store) state_nxt = MEM;
                else                          state_nxt = WB;
            end
            MEM: begin
                RAddr = {2'b00, ea[31:2]};
                if (is_load) begin
                    RRdy = 1'b1;
                    if (RVld) state_nxt = WB;
                end else begin
                    RWEn      = !rstn;
                    state_nxt = WB;
                    case (funct3)
                        3'b000: begin
                            RWStrobe = rstn ? 4'd0 : (4'b0001 << ea[1:0]);
                            RWData   = {24'd0, result[7:0]} << {ea[1:0], 3'b000};
                        end
                        3'b001: begin
                            RWStrobe = rstn ? 4'd0 : (ea[1] ? 4'b1100 : 4'b0011);
                            RWData   = ea[1] ? {result[15:0], 16'd0} : {16'd0, result[15:0]};
                        end
                        default: begin
                            RWStrobe = rstn ? 4'd0 : 4'b1111;
                            RWData   = result;
                        end
                    endcase
                end
            end
            WB:   state_nxt = FETCH;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lanzones.sv
// Bench for lanzones: small programs run against zero-latency and one-cycle
// memory; expected memory writes are queued up front and matched as they occur.
module tb_lanzones;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        LEn = 1'b0;
    logic        RRdy, RVld, RWEn, Halt;
    logic [31:0] RAddr, RData, RWData;
    logic [3:0]  RWStrobe;

    logic        zero_lat = 1'b1;
    logic        rvld_q = 1'b0;
    logic [31:0] mem  [0:511];
    logic [31:0] snap [0:511];
    logic [31:0] mon_word;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] word;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  late_writes = 0;

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] OPI  = 7'b0010011;

    lanzones dut (
        .clk(clk), .rstn(rstn), .LEn(LEn),
        .RRdy(RRdy), .RAddr(RAddr), .RVld(RVld), .RData(RData),
        .RWEn(RWEn), .RWData(RWData), .RWStrobe(RWStrobe), .Halt(Halt)
    );

    always #5 clk = ~clk;

    assign RVld  = zero_lat ? 1'b1 : rvld_q;
    assign RData = mem[RAddr[8:0]];

    // One-cycle memory answers a raised RRdy on the following cycle
    always @(posedge clk) begin
        if (rstn) rvld_q <= 1'b0;
        else      rvld_q <= RRdy && !rvld_q;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (RWEn) begin
            mon_word = mem[RAddr[8:0]];
            for (int i = 0; i < 4; i++)
                if (RWStrobe[i]) mon_word[8*i +: 8] = RWData[8*i +: 8];
            mem[RAddr[8:0]] = mon_word;
            if (Halt) late_writes++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_write_count", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", RAddr, e.addr);
                checkOutput("wr_strobe", {28'd0, RWStrobe}, {28'd0, e.strb});
                checkOutput("wr_word", mon_word, e.word);
            end
        end
    end

    function automatic logic [31:0] encI(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encB(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic pushExp(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] word);
        wr_t e;
        e.addr = addr;
        e.strb = strb;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic loadProgram(input int id);
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        exp_q.delete();
        case (id)
            1: begin
                mem[0] = encI(5, 0, 3'b000, 1, OPI);
                mem[1] = encI(7, 0, 3'b000, 2, OPI);
                mem[2] = encR(7'd0, 2, 1, 3'b000, 3);
                mem[3] = encS(32'h400, 3, 0, 3'b010);
                mem[4] = 32'h00000073;
                pushExp(32'h100, 4'b1111, 32'h0000000C);
            end
            2: begin
                mem[32'h100] = 32'hFFFFFFFF;
                mem[0] = encI(32'hAB, 0, 3'b000, 1, OPI);
                mem[1] = encS(32'h401, 1, 0, 3'b000);
                mem[2] = 32'h00000073;
                pushExp(32'h100, 4'b0010, 32'hFFFFABFF);
            end
            3: begin
                mem[32'h100] = 32'h00008000;
                mem[32'h101] = 32'h55555555;
                mem[32'h102] = 32'h55555555;
                mem[0] = encI(32'h401, 0, 3'b000, 1, LOAD);
                mem[1] = encI(32'h401, 0, 3'b100, 2, LOAD);
                mem[2] = encS(32'h404, 1, 0, 3'b010);
                mem[3] = encS(32'h408, 2, 0, 3'b010);
                mem[4] = 32'h00100073;
                pushExp(32'h101, 4'b1111, 32'hFFFFFF80);
                pushExp(32'h102, 4'b1111, 32'h00000080);
            end
            4: begin
                mem[32'h100] = 32'hDEADBEEF;
                mem[0] = encI(3, 0, 3'b000, 1, OPI);
                mem[1] = encI(32'hFFFFFFFF, 1, 3'b000, 1, OPI);
                mem[2] = encB(32'hFFFFFFFC, 0, 1, 3'b001);
                mem[3] = encS(32'h400, 1, 0, 3'b010);
                mem[4] = 32'h00100073;
                pushExp(32'h100, 4'b1111, 32'h00000000);
            end
            default: begin
                mem[32'h104] = 32'h12345678;
                mem[0]  = 32'h800000B7;
                mem[1]  = encI(32'h404, 1, 3'b101, 2, OPI);
                mem[2]  = encI(32'h004, 1, 3'b101, 3, OPI);
                mem[3]  = encR(7'd0, 0, 1, 3'b010, 4);
                mem[4]  = encR(7'd0, 0, 1, 3'b011, 5);
                mem[5]  = encI(32'hFFFFFFFE, 0, 3'b000, 7, OPI);
                mem[6]  = encS(32'h400, 2, 0, 3'b010);
                mem[7]  = encS(32'h404, 3, 0, 3'b010);
                mem[8]  = encS(32'h408, 4, 0, 3'b010);
                mem[9]  = encS(32'h410, 5, 0, 3'b010);
                mem[10] = encS(32'h40E, 7, 0, 3'b001);
                mem[11] = 32'h00000073;
                pushExp(32'h100, 4'b1111, 32'hF8000000);
                pushExp(32'h101, 4'b1111, 32'h08000000);
                pushExp(32'h102, 4'b1111, 32'h00000001);
                pushExp(32'h104, 4'b1111, 32'h00000000);
                pushExp(32'h103, 4'b1100, 32'hFFFE0000);
            end
        endcase
    endtask

    task automatic applyStimulus(input int id, input logic zl);
        int cyc;
        int rrdy_halt;
        rstn     = 1'b1;
        LEn      = 1'b0;
        zero_lat = zl;
        loadProgram(id);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        late_writes = 0;
        @(posedge clk);
        #1 LEn = 1'b1;
        @(posedge clk);
        #1 LEn = 1'b0;
        cyc = 0;
        while (!Halt && cyc < 3000) begin
            @(posedge clk);
            #1 cyc++;
        end
        checkOutput($sformatf("halted_p%0d_zl%0d", id, zl), {31'd0, Halt}, 32'd1);
        rrdy_halt = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (RRdy) rrdy_halt++;
        end
        checkOutput("halt_sticky", {31'd0, Halt}, 32'd1);
        checkOutput("rrdy_in_halt", rrdy_halt, 32'd0);
        checkOutput("writes_after_halt", late_writes, 32'd0);
        checkOutput("pending_writes", exp_q.size(), 32'd0);
    endtask

    initial begin
        int bad;
        int ndiff;
        $display("[TB] reset and idle checks");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rrdy", {31'd0, RRdy}, 32'd0);
        checkOutput("rst_rwen", {31'd0, RWEn}, 32'd0);
        checkOutput("rst_halt", {31'd0, Halt}, 32'd0);
        checkOutput("rst_strobe", {28'd0, RWStrobe}, 32'd0);
        checkOutput("rst_raddr", RAddr, 32'd0);
        checkOutput("rst_rwdata", RWData, 32'd0);
        rstn = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (RRdy || RWEn || Halt) bad++;
        end
        checkOutput("idle_quiet", bad, 32'd0);

        for (int p = 1; p <= 5; p++) begin
            $display("[TB] program %0d", p);
            applyStimulus(p, 1'b1);
            for (int i = 0; i < 512; i++) snap[i] = mem[i];
            applyStimulus(p, 1'b0);
            ndiff = 0;
            for (int i = 0; i < 512; i++) if (mem[i] !== snap[i]) ndiff++;
            checkOutput("latency_mem_diff", ndiff, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
